mem_ctrl: RTL and testbench
===========================

// Module: mem_ctrl
// PURPOSE
//  Multi-cycle memory access controller between datapath and word-addressed 16-bit memory.
//  Accepts one load/store request, drives the memory bus until memory asserts ready, then
//  returns load data aligned and sign-extended.
//  rdata feeds the 16-bit data-select mux ahead of MDR/regfile writeback.
//  Handles word (LDW/STW) and byte (LDB/STB) accesses; little-endian byte lanes.
// PARAMETERS
//  MAX_WAIT  16  cycles in ACCESS without mem_r before bus-error abort (min 1, max 255)
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  reset      in   1   synchronous, active-high reset
//  req        in   1   start access; sampled only in IDLE
//  we         in   1   1=store, 0=load; sampled with req
//  byte       in   1   1=byte access, 0=word access; sampled with req
//  addr       in   16  byte address; sampled with req
//  wdata      in   16  store data; sampled with req (byte store uses wdata[7:0])
//  rdata      out  16  load result; valid while done=1
//  done       out  1   one-cycle pulse: access complete (load or store)
//  busy       out  1   1 in any state other than IDLE
//  bus_err    out  1   one-cycle pulse with done when MAX_WAIT expires
//  fault      out  1   one-cycle pulse on unaligned word access (UNALIGNED_TRAP_EN only)
//  mem_en     out  1   memory enable; high throughout ACCESS
//  mem_we     out  2   byte-lane write enables {hi,lo}; nonzero only in ACCESS on stores
//  mem_addr   out  15  word address = addr[15:1]
//  mem_wdata  out  16  store data to memory
//  mem_rdata  in   16  memory read data; valid when mem_r=1
//  mem_r      in   1   memory ready; completes access in the cycle it is high during ACCESS
// BEHAVIOUR
//  - Reset: state=IDLE; rdata=0, done=0, busy=0, bus_err=0, fault=0, mem_en=0, mem_we=0,
//    mem_addr=0, mem_wdata=0, wait counter=0. Reset in any state aborts; no done pulse.
//  - FSM states: IDLE, ACCESS, DONE (+FAULT when macro defined).
//  - IDLE: req=1 -> latch we/byte/addr/wdata, clear wait counter, go ACCESS next cycle.
//    req while busy is ignored (not queued).
//  - ACCESS: mem_en=1; mem_addr=addr[15:1].
//    Store word: mem_we=2'b11, mem_wdata=wdata.
//    Store byte: mem_wdata={wdata[7:0],wdata[7:0]}, mem_we=addr[0]?2'b10:2'b01.
//    Load: mem_we=2'b00.
//    mem_r=1 -> capture data, go DONE. Else counter++; counter==MAX_WAIT-1 with mem_r=0
//    -> go DONE with bus_err flagged, rdata=16'h0000.
//  - Load data: word -> rdata=mem_rdata; byte -> selected lane (addr[0]=1: [15:8],
//    else [7:0]) sign-extended to 16 bits.
//  - Word access with addr[0]=1 (no macro): bit 0 ignored, even-aligned access performed.
//  - DONE: done=1 (and bus_err if flagged) for exactly one cycle; mem_en=0; go IDLE.
//    rdata holds its value until next load completes; stores leave rdata unchanged.
//  - Minimum latency: req at cycle N, mem_r=1 at N+1 -> done at N+2; back-to-back req
//    accepted in the cycle after done (IDLE).
//  - mem_r outside ACCESS is ignored.
// CONFIGURATION
//  UNALIGNED_TRAP_EN defined: req with byte=0 and addr[0]=1 -> IDLE->FAULT (no bus cycle,
//    mem_en stays 0); FAULT pulses fault=1 and done=1 for one cycle, rdata unchanged, -> IDLE.
//  Not defined: fault tied 0, FAULT state absent, unaligned word access handled as above.
// TESTING
//  1. Word load addr=16'h3002, mem_rdata=16'hBEEF, mem_r at 2nd ACCESS cycle
//     -> mem_addr=15'h1801, done 1 cycle, rdata=16'hBEEF, busy high 3 cycles.
//  2. Byte load addr=16'h3003, mem_rdata=16'h80_12 -> rdata=16'hFF80;
//     addr=16'h3002 -> rdata=16'h0012.
//  3. Byte store addr=16'h0005, wdata=16'h12AB -> mem_we=2'b10, mem_wdata=16'hABAB;
//     rdata unchanged.
//  4. MAX_WAIT=4, mem_r held 0 -> after 4 ACCESS cycles done=1, bus_err=1, rdata=0.
//  5. Reset asserted during ACCESS -> next cycle IDLE, all outputs 0, no done pulse;
//     req during busy ignored.
//  6. UNALIGNED_TRAP_EN: word load addr=16'h0001 -> fault=1, done=1, mem_en never 1;
//     without macro -> mem_addr=0, normal load.

Source files
------------

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl : multi-cycle load/store controller for a word-addressed 16-bit
// memory with little-endian byte lanes. One request is taken in IDLE. The
// memory bus is driven until mem_r is seen or the wait budget runs out. Load
// data is returned aligned and sign-extended (byte) on a one-cycle done pulse.
// Optional feature macro: UNALIGNED_TRAP_EN (trap unaligned word accesses).
// The byte-access select is carried on port is_byte.
// ---------------------------------------------------------------------------
module mem_ctrl #(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic        is_byte,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        done,
   output logic        busy,
   output logic        bus_err,
   output logic        fault,
   output logic        mem_en,
   output logic [1:0]  mem_we,
   output logic [14:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_r
);

`ifdef UNALIGNED_TRAP_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2, ST_FAULT = 2'd3} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_DONE = 2'd2} state_t;
`endif

   // Last wait-counter value before the access is abandoned as a bus error.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t     state_r;
   logic [7:0] wait_r;
   logic       we_r;
   logic       byte_r;
   logic       lane_r;

`ifdef UNALIGNED_TRAP_EN
   logic       fault_r;
   assign fault = fault_r;
`else
   assign fault = 1'b0;
`endif

   // Pick the addressed lane for byte loads and sign-extend it; words pass through.
   function automatic logic [15:0] load_align(input logic [15:0] word,
                                              input logic        is_b,
                                              input logic        hi);
      logic [7:0] lane;
      lane = hi ? word[15:8] : word[7:0];
      if (is_b) begin
         load_align = {{8{lane[7]}}, lane};
      end else begin
         load_align = word;
      end
   endfunction

   // Byte-lane write enables for a store: both lanes for words, one lane for bytes.
   function automatic logic [1:0] lane_we(input logic w, input logic is_b, input logic hi);
      if (!w) begin
         lane_we = 2'b00;
      end else if (!is_b) begin
         lane_we = 2'b11;
      end else begin
         lane_we = hi ? 2'b10 : 2'b01;
      end
   endfunction

   // Access FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         wait_r    <= 8'h00;
         we_r      <= 1'b0;
         byte_r    <= 1'b0;
         lane_r    <= 1'b0;
         rdata     <= 16'h0000;
         done      <= 1'b0;
         busy      <= 1'b0;
         bus_err   <= 1'b0;
         mem_en    <= 1'b0;
         mem_we    <= 2'b00;
         mem_addr  <= 15'h0000;
         mem_wdata <= 16'h0000;
`ifdef UNALIGNED_TRAP_EN
         fault_r   <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done    <= 1'b0;
               bus_err <= 1'b0;
               if (req) begin
`ifdef UNALIGNED_TRAP_EN
                  if (!is_byte && addr[0]) begin
                     // Unaligned word: no bus cycle, report through FAULT.
                     state_r <= ST_FAULT;
                     fault_r <= 1'b1;
                     done    <= 1'b1;
                     busy    <= 1'b1;
                  end else
`endif
                  begin
                     state_r   <= ST_ACCESS;
                     busy      <= 1'b1;
                     wait_r    <= 8'h00;
                     we_r      <= we;
                     byte_r    <= is_byte;
                     lane_r    <= addr[0];
                     mem_en    <= 1'b1;
                     mem_addr  <= addr[15:1];
                     mem_we    <= lane_we(we, is_byte, addr[0]);
                     mem_wdata <= is_byte ? {wdata[7:0], wdata[7:0]} : wdata;
                  end
               end else begin
                  busy <= 1'b0;
               end
            end
            ST_ACCESS: begin
               if (mem_r) begin
                  if (!we_r) begin
                     rdata <= load_align(mem_rdata, byte_r, lane_r);
                  end
                  state_r <= ST_DONE;
                  done    <= 1'b1;
                  mem_en  <= 1'b0;
                  mem_we  <= 2'b00;
               end else if (wait_r == WAIT_LAST) begin
                  // Memory never answered: abort with a bus error and zero data.
                  rdata   <= 16'h0000;
                  state_r <= ST_DONE;
                  done    <= 1'b1;
                  bus_err <= 1'b1;
                  mem_en  <= 1'b0;
                  mem_we  <= 2'b00;
               end else begin
                  wait_r <= wait_r + 8'd1;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done    <= 1'b0;
               bus_err <= 1'b0;
               busy    <= 1'b0;
            end
`ifdef UNALIGNED_TRAP_EN
            ST_FAULT: begin
               state_r <= ST_IDLE;
               done    <= 1'b0;
               fault_r <= 1'b0;
               busy    <= 1'b0;
            end
`endif
            default: begin
               state_r <= ST_IDLE;
               done    <= 1'b0;
               bus_err <= 1'b0;
               busy    <= 1'b0;
               mem_en  <= 1'b0;
               mem_we  <= 2'b00;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl : directed and random load/store traffic against mem_ctrl.
// The bench plays the memory (a small word array) and keeps the expected
// load result at transaction level.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

   localparam int MW = 4;

   logic        clk = 1'b0;
   logic        reset, req, we, is_byte, mem_r;
   logic [15:0] addr, wdata, mem_rdata;
   logic [15:0] rdata, mem_wdata;
   logic        done, busy, bus_err, fault, mem_en;
   logic [1:0]  mem_we;
   logic [14:0] mem_addr;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [15:0] mem [0:31];
   logic [15:0] last_rd;

   mem_ctrl #(.MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .is_byte(is_byte),
      .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
      .bus_err(bus_err), .fault(fault), .mem_en(mem_en), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_r(mem_r)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit trap(input logic b, input logic [15:0] a);
`ifdef UNALIGNED_TRAP_EN
      return (!b && a[0]);
`else
      return 1'b0;
`endif
   endfunction

   // One complete transaction; dly = ACCESS cycles before mem_r (>= MW means never).
   task automatic access(input logic w, input logic b, input logic [15:0] a,
                         input logic [15:0] wd, input int dly, input bit noise);
      int          idx;
      int          n;
      bit          tmo;
      logic [7:0]  lane;
      logic [15:0] word;
      logic [1:0]  exp_we;
      idx = int'(a[5:1]);
      @(negedge clk);
      req = 1'b1; we = w; is_byte = b; addr = a; wdata = wd;
      @(posedge clk); #1;
      req = noise; we = 1'($urandom); is_byte = 1'($urandom);
      addr = 16'($urandom); wdata = 16'($urandom);
      if (trap(b, a)) begin
         check("fault_pulse", fault, 1'b1);
         check("fault_done", done, 1'b1);
         check("fault_mem_en", mem_en, 1'b0);
         check("fault_rdata", rdata, last_rd);
         check("fault_busy", busy, 1'b1);
      end else begin
         tmo = (dly >= MW);
         n   = tmo ? MW : dly + 1;
         if (!w) exp_we = 2'b00;
         else if (!b) exp_we = 2'b11;
         else exp_we = a[0] ? 2'b10 : 2'b01;
         for (int k = 0; k < n; k++) begin
            check("acc_busy", busy, 1'b1);
            check("acc_mem_en", mem_en, 1'b1);
            check("acc_done", done, 1'b0);
            check("acc_mem_addr", mem_addr, a[15:1]);
            check("acc_mem_we", mem_we, exp_we);
            if (w) check("acc_mem_wdata", mem_wdata, b ? {wd[7:0], wd[7:0]} : wd);
            mem_r     = (k == dly);
            mem_rdata = (k == dly && !w) ? mem[idx] : 16'($urandom);
            if (noise) addr = 16'($urandom);
            @(posedge clk); #1;
         end
         mem_r = noise;
         mem_rdata = 16'($urandom);
         if (tmo) begin
            last_rd = 16'h0000;
         end else if (w) begin
            if (!b) mem[idx] = wd;
            else if (a[0]) mem[idx][15:8] = wd[7:0];
            else mem[idx][7:0] = wd[7:0];
         end else begin
            word = mem[idx];
            if (b) begin
               lane = a[0] ? word[15:8] : word[7:0];
               last_rd = (lane >= 8'd128) ? (16'(lane) + 16'hFF00) : 16'(lane);
            end else begin
               last_rd = word;
            end
         end
         check("done_pulse", done, 1'b1);
         check("done_bus_err", bus_err, tmo);
         check("done_rdata", rdata, last_rd);
         check("done_mem_en", mem_en, 1'b0);
         check("done_mem_we", mem_we, 2'b00);
         check("done_fault", fault, 1'b0);
         check("done_busy", busy, 1'b1);
      end
      @(posedge clk); #1;
      req = 1'b0; mem_r = 1'b0;
      check("idle_done", done, 1'b0);
      check("idle_bus_err", bus_err, 1'b0);
      check("idle_fault", fault, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_rdata", rdata, last_rd);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rdata"}, rdata, 16'h0000);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_bus_err"}, bus_err, 1'b0);
      check({tag, "_fault"}, fault, 1'b0);
      check({tag, "_mem_en"}, mem_en, 1'b0);
      check({tag, "_mem_we"}, mem_we, 2'b00);
      check({tag, "_mem_addr"}, mem_addr, 15'h0000);
      check({tag, "_mem_wdata"}, mem_wdata, 16'h0000);
   endtask

   initial begin
      reset = 1'b1; req = 1'b0; we = 1'b0; is_byte = 1'b0; mem_r = 1'b0;
      addr = 16'h0000; wdata = 16'h0000; mem_rdata = 16'h0000;
      last_rd = 16'h0000;
      for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset");
      @(negedge clk); reset = 1'b0;

      // Word load, ready on the second ACCESS cycle.
      mem[1] = 16'hBEEF;
      access(1'b0, 1'b0, 16'h3002, 16'h0000, 1, 1'b0);
      check("word_load_beef", rdata, 16'hBEEF);

      // Byte loads from both lanes, sign extension.
      mem[1] = 16'h8012;
      access(1'b0, 1'b1, 16'h3003, 16'h0000, 0, 1'b0);
      check("byte_hi_sext", rdata, 16'hFF80);
      access(1'b0, 1'b1, 16'h3002, 16'h0000, 0, 1'b1);
      check("byte_lo_zext", rdata, 16'h0012);

      // Byte store to the high lane leaves rdata alone.
      access(1'b1, 1'b1, 16'h0005, 16'h12AB, 2, 1'b1);
      check("store_keeps_rdata", rdata, 16'h0012);

      // Memory never ready: bus error with zero data.
      access(1'b0, 1'b0, 16'h0020, 16'h0000, 10, 1'b1);
      check("timeout_rdata", rdata, 16'h0000);

      // Unaligned word load.
      mem[0] = 16'h5A3C;
      access(1'b0, 1'b0, 16'h0001, 16'h0000, 0, 1'b0);
`ifndef UNALIGNED_TRAP_EN
      check("unaligned_word_data", rdata, 16'h5A3C);
`endif

      // Reset in the middle of ACCESS aborts without a done pulse.
      @(negedge clk);
      req = 1'b1; we = 1'b0; is_byte = 1'b0; addr = 16'h0010;
      @(posedge clk); #1;
      req = 1'b0;
      check("pre_reset_mem_en", mem_en, 1'b1);
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      check_all_zero("midreset");
      @(negedge clk); reset = 1'b0;
      last_rd = 16'h0000;
      @(posedge clk); #1;
      check("post_reset_done", done, 1'b0);
      check("post_reset_busy", busy, 1'b0);

      // Random traffic, back-to-back, with noise on req/mem_r while busy.
      for (int t = 0; t < 60; t++) begin
         access(1'($urandom), 1'($urandom), 16'($urandom_range(0, 63)),
                16'($urandom), $urandom_range(0, 5), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
